txc_port_sched: RTL and testbench

TXC_PORT_SCHED -- requirements
Module: txc_port_sched

---
 rtl/txc_port_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_txc_port_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txc_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : txc_port_sched
// Desc     : Credit-gated round-robin EPL port scheduler with packet locking.
// Options  : define TXC_PKT_CNT_EN to add per-port eop packet counters (pkt_cnt)
// Revision : 1.0 - initial release
// ============================================================================
module txc_port_sched #(
    parameter int  NUM_PORTS = 4,
    parameter int  DATA_W    = 512,
    parameter int  MAX_CRD   = 16,
    localparam int CRD_W     = $clog2(MAX_CRD + 1),
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data,
    input  logic [NUM_PORTS-1:0]        req_sop,
    input  logic [NUM_PORTS-1:0]        req_eop,
    input  logic [NUM_PORTS-1:0]        crd_ret,
    output logic                        tx_valid,
    output logic [PORT_W-1:0]           tx_port,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_sop,
    output logic                        tx_eop,
    output logic [NUM_PORTS*CRD_W-1:0]  crd_avail,
    output logic [NUM_PORTS-1:0]        crd_ovf_err
`ifdef TXC_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]     pkt_cnt
`endif
);

    localparam logic [0:0]       c_st_idle   = 1'b0;
    localparam logic [0:0]       c_st_locked = 1'b1;
    localparam logic [CRD_W-1:0] c_max_crd   = CRD_W'(MAX_CRD);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [PORT_W-1:0]    r_lock_port;
    logic [PORT_W-1:0]    r_rr_ptr;
    logic [CRD_W-1:0]     r_credit [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_ovf;

    logic [DATA_W-1:0]    w_seg_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_grant;
    logic [PORT_W-1:0]    w_grant_idx;
    logic                 w_xfer;
    logic                 w_xfer_sop;
    logic                 w_xfer_eop;
    logic [DATA_W-1:0]    w_xfer_data;
    logic                 w_lock_start;

    // While a packet is locked only its owner may compete, so segments never interleave.
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_seg_data[p] = req_data[p*DATA_W +: DATA_W];
            assign w_elig[p]     = req_valid[p] && (r_credit[p] != '0) &&
                                   ((r_state == c_st_idle) || (r_lock_port == PORT_W'(p)));
            assign crd_avail[p*CRD_W +: CRD_W] = r_credit[p];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_xfer && w_xfer_sop && !w_xfer_eop) begin
                    w_state_nxt = c_st_locked;
                end
            end
            c_st_locked: begin
                if (w_xfer && w_xfer_eop) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic -- round-robin grant starting at r_rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        logic              w_found;
        logic [PORT_W:0]   w_sum;
        logic [PORT_W-1:0] w_idx;
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_sum = {1'b0, r_rr_ptr} + (PORT_W+1)'(i);
                if (w_sum >= (PORT_W+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (PORT_W+1)'(NUM_PORTS);
                end
                w_idx = w_sum[PORT_W-1:0];
                if (!w_found && w_elig[w_idx]) begin
                    w_found        = 1'b1;
                    w_grant[w_idx] = 1'b1;
                    w_grant_idx    = w_idx;
                end
            end
        end
    end

    assign req_ready    = w_grant;
    assign w_xfer       = |w_grant;
    assign w_xfer_sop   = req_sop[w_grant_idx];
    assign w_xfer_eop   = req_eop[w_grant_idx];
    assign w_xfer_data  = w_seg_data[w_grant_idx];
    assign w_lock_start = (r_state == c_st_idle) && (w_state_nxt == c_st_locked);

    // The pointer only moves at packet boundaries so a multi-segment packet keeps its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_port <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_lock_start) begin
                r_lock_port <= w_grant_idx;
            end
            if (w_xfer && w_xfer_eop) begin
                r_rr_ptr <= (w_grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                     : w_grant_idx + PORT_W'(1);
            end
        end
    end

    // Credit accounting: a spend and a return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_credit[p] <= c_max_crd;
            end
            r_ovf <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                case ({crd_ret[p], w_grant[p]})
                    2'b10: begin
                        if (r_credit[p] == c_max_crd) begin
                            r_ovf[p] <= 1'b1;
                        end else begin
                            r_credit[p] <= r_credit[p] + CRD_W'(1);
                        end
                    end
                    2'b01:   r_credit[p] <= r_credit[p] - CRD_W'(1);
                    default: r_credit[p] <= r_credit[p];
                endcase
            end
        end
    end

    assign crd_ovf_err = r_ovf;

    // Egress register; payload fields hold when no segment moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_port  <= '0;
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
        end else begin
            tx_valid <= w_xfer;
            if (w_xfer) begin
                tx_port <= w_grant_idx;
                tx_data <= w_xfer_data;
                tx_sop  <= w_xfer_sop;
                tx_eop  <= w_xfer_eop;
            end
        end
    end

`ifdef TXC_PKT_CNT_EN
    logic [31:0] r_pkt_cnt [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pkt_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant[p] && req_eop[p]) begin
                    r_pkt_cnt[p] <= r_pkt_cnt[p] + 32'd1;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pkt_cnt
            assign pkt_cnt[p*32 +: 32] = r_pkt_cnt[p];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_txc_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_txc_port_sched
// Desc     : Scoreboard bench for txc_port_sched against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_txc_port_sched;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int MC = 16;
    localparam int CW = 5;
    localparam int PW = 2;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic        sop;
        logic        eop;
    } tx_t;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_ready;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0]   req_sop;
    logic [NP-1:0]   req_eop;
    logic [NP-1:0]   crd_ret;
    logic            tx_valid;
    logic [PW-1:0]   tx_port;
    logic [DW-1:0]   tx_data;
    logic            tx_sop;
    logic            tx_eop;
    logic [NP*CW-1:0] crd_avail;
    logic [NP-1:0]   crd_ovf_err;
`ifdef TXC_PKT_CNT_EN
    logic [NP*32-1:0] pkt_cnt;
`endif

    txc_port_sched #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .MAX_CRD   (MC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_sop     (req_sop),
        .req_eop     (req_eop),
        .crd_ret     (crd_ret),
        .tx_valid    (tx_valid),
        .tx_port     (tx_port),
        .tx_data     (tx_data),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .crd_avail   (crd_avail),
        .crd_ovf_err (crd_ovf_err)
`ifdef TXC_PKT_CNT_EN
        ,
        .pkt_cnt     (pkt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    tx_t sb[$];

    // Reference model state: credits, lock owner (-1 = none), round-robin start.
    int          m_crd [NP];
    bit          m_ovf [NP];
    int          m_lock;
    int          m_rr;
    int unsigned m_pkt [NP];

    // Per-port packet generator: current packet length and segment index.
    int g_len [NP];
    int g_seg [NP];
    bit g_rand;

    logic [NP-1:0] rdy_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_crd[p] = MC;
            m_ovf[p] = 1'b0;
            m_pkt[p] = 0;
            g_seg[p] = 0;
        end
        m_lock = -1;
        m_rr   = 0;
    endtask

    // Checks the current cycle against the model, then advances the model across the edge.
    task automatic tick();
        int g;
        #1;
        rdy_seen = req_ready;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_rr + k) % NP;
                if (g < 0 && req_valid[p] && m_crd[p] > 0 && (m_lock < 0 || m_lock == p)) g = p;
            end
        end
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        for (int p = 0; p < NP; p++) begin
            chk("crd_avail", 64'(crd_avail[p*CW +: CW]), 64'(m_crd[p]));
            chk("crd_ovf_err", 64'(crd_ovf_err[p]), 64'(m_ovf[p]));
`ifdef TXC_PKT_CNT_EN
            chk("pkt_cnt", 64'(pkt_cnt[p*32 +: 32]), 64'(m_pkt[p]));
`endif
        end
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (crd_ret[p] && g != p) begin
                    if (m_crd[p] == MC) m_ovf[p] = 1'b1;
                    else                m_crd[p] = m_crd[p] + 1;
                end else if (!crd_ret[p] && g == p) begin
                    m_crd[p] = m_crd[p] - 1;
                end
            end
            if (g >= 0) begin
                sb.push_back('{g, req_data[g*DW +: DW], req_sop[g], req_eop[g]});
                if (m_lock < 0 && req_sop[g] && !req_eop[g]) m_lock = g;
                else if (m_lock == g && req_eop[g])         m_lock = -1;
                if (req_eop[g]) begin
                    m_rr     = (g + 1) % NP;
                    m_pkt[g] = m_pkt[g] + 1;
                end
                g_seg[g] = g_seg[g] + 1;
                if (g_seg[g] == g_len[g]) begin
                    g_seg[g] = 0;
                    g_len[g] = g_rand ? int'($urandom_range(1, 4)) : 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [NP-1:0] mask, input logic [NP-1:0] ret, input logic r);
        rst     = r;
        crd_ret = ret;
        for (int p = 0; p < NP; p++) begin
            req_valid[p]          = mask[p];
            req_sop[p]            = (g_seg[p] == 0);
            req_eop[p]            = (g_seg[p] == g_len[p] - 1);
            req_data[p*DW +: DW]  = {$urandom, $urandom};
        end
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a segment.
    initial begin
        tx_t e;
        tx_t last;
        last.port = 0;
        last.data = '0;
        last.sop  = 1'b0;
        last.eop  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_tx_valid", 64'(tx_valid), 64'd0);
                chk("rst_tx_port",  64'(tx_port),  64'd0);
                chk("rst_tx_data",  64'(tx_data),  64'd0);
                chk("rst_tx_sop",   64'(tx_sop),   64'd0);
                chk("rst_tx_eop",   64'(tx_eop),   64'd0);
                last.port = 0;
                last.data = '0;
                last.sop  = 1'b0;
                last.eop  = 1'b0;
            end else if (tx_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: actual port=%0d expected no segment", tx_port);
                end else begin
                    e = sb.pop_front();
                    chk("tx_port", 64'(tx_port), 64'(e.port));
                    chk("tx_data", 64'(tx_data), 64'(e.data));
                    chk("tx_sop",  64'(tx_sop),  64'(e.sop));
                    chk("tx_eop",  64'(tx_eop),  64'(e.eop));
                    last = e;
                end
            end else begin
                chk("hold_port", 64'(tx_port), 64'(last.port));
                chk("hold_data", 64'(tx_data), 64'(last.data));
                chk("hold_sop",  64'(tx_sop),  64'(last.sop));
                chk("hold_eop",  64'(tx_eop),  64'(last.eop));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_data  = '0;
        crd_ret   = '0;
        g_rand    = 1'b0;
        for (int p = 0; p < NP; p++) g_len[p] = 1;
        model_reset();
        @(negedge clk);
        drive('0, '0, 1'b1);
        drive('0, '0, 1'b1);

        // Single-segment packets on all ports rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, '0, 1'b0);
            chk("rr_sequence", 64'(rdy_seen), 64'd1 << (i % NP));
        end

        // Port 1 three-segment packet blocks port 2 until its eop.
        g_len[1] = 3;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0110, '0, 1'b0);
            chk("lock_sequence", 64'(rdy_seen), (i < 3) ? 64'h2 : 64'h4);
        end

        // Credit exhaustion on port 0 and recovery after one return.
        drive('0, '0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(4'b0001, '0, 1'b0);
            chk("drain_grant", 64'(rdy_seen), 64'h1);
        end
        drive(4'b0001, '0, 1'b0);
        chk("starved_ready", 64'(rdy_seen), 64'h0);
        chk("starved_credit", 64'(crd_avail[CW-1:0]), 64'd0);
        drive(4'b0001, 4'b0001, 1'b0);
        chk("return_cycle_ready", 64'(rdy_seen), 64'h0);
        drive(4'b0001, '0, 1'b0);
        chk("after_return_ready", 64'(rdy_seen), 64'h1);

        // Return into a full port 3 saturates and flags overflow.
        drive('0, 4'b1000, 1'b0);
        chk("ovf_flag", 64'(crd_ovf_err[3]), 64'd1);
        chk("ovf_saturate", 64'(crd_avail[3*CW +: CW]), 64'd16);

        // Port 2 at credit 5 with simultaneous spend and return.
        for (int i = 0; i < 11; i++) drive(4'b0100, '0, 1'b0);
        chk("credit_five", 64'(crd_avail[2*CW +: CW]), 64'd5);
        drive(4'b0100, 4'b0100, 1'b0);
        chk("same_cycle_grant", 64'(rdy_seen), 64'h4);
        chk("same_cycle_credit", 64'(crd_avail[2*CW +: CW]), 64'd5);
        chk("ovf_sticky", 64'(crd_ovf_err[3]), 64'd1);

        // Reset mid-packet drops the lock; port 1 wins right after.
        drive('0, '0, 1'b1);
        g_len[0] = 4;
        g_len[1] = 1;
        drive(4'b0011, '0, 1'b0);
        chk("pkt_sop_grant", 64'(rdy_seen), 64'h1);
        drive(4'b0011, '0, 1'b0);
        chk("pkt_seg2_grant", 64'(rdy_seen), 64'h1);
        drive(4'b0011, '0, 1'b1);
        chk("rst_ready", 64'(rdy_seen), 64'h0);
        drive(4'b0010, '0, 1'b0);
        chk("post_rst_grant", 64'(rdy_seen), 64'h2);
        chk("post_rst_ovf", 64'(crd_ovf_err), 64'h0);
        chk("post_rst_credit0", 64'(crd_avail[CW-1:0]), 64'd16);

        // Randomized traffic: a credit-starved phase, then a return-heavy phase.
        drive('0, '0, 1'b1);
        g_rand = 1'b1;
        for (int p = 0; p < NP; p++) g_len[p] = int'($urandom_range(1, 4));
        for (int i = 0; i < 3000; i++) begin
            logic [NP-1:0] m;
            logic [NP-1:0] ret;
            m = NP'($urandom | $urandom);
            for (int p = 0; p < NP; p++) begin
                ret[p] = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            end
            drive(m, ret, ($urandom_range(0, 299) == 0));
        end
        drive('0, '0, 1'b0);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
